// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit path and, later, the receive path.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT  bit period in system clocks (12 MHz / 115200 baud)
//   PARITY_NONE/EVEN/ODD  parity mode selectors for the PARITY parameter
//   tx_state_e            transmitter FSM encoding, also driven on the debug port
//   parity_bit()          parity bit for one data byte in a given mode
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity makes the total count of ones (data + parity) even, so the
    // parity bit is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
//
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps to 0 on its own, so
// consecutive bit periods are exactly CLKS_PER_BIT cycles with no drift.
// While restart_i is high the count is held at 0; the first period starts
// in the cycle restart_i drops.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   restart_i  in   hold the timer at count 0 (no ticks while high)
//   tick_o     out  high in the last cycle of each bit period
//                   (count == CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = !restart_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// 8-bit asynchronous serial transmitter: idle-high line, one start bit, eight
// data bits LSB first, optional even/odd parity, one or two stop bits.
// A one-entry holding register in front of the shift register lets the next
// byte be accepted while the current frame is still on the line, so frames
// can run back-to-back with no idle cycles in between.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period, 2..255
//   PARITY        PARITY_NONE (0), PARITY_EVEN (1), PARITY_ODD (2)
//   STOP_BITS     1 or 2
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   data_in      in   byte to send
//   data_valid   in   producer has a byte on data_in
//   data_ready   out  holding register empty
//   tx           out  serial line, registered, idle high
//   busy         out  high from first start-bit cycle to last stop-bit cycle
//   tx_done      out  one-cycle pulse in the last cycle of the final stop bit
//   dbg_state_o  out  current FSM state
//
// Handshake: a byte transfers on every rising clk edge where data_valid and
// data_ready are both high. data_ready is a registered flag (holding register
// empty) and never depends combinationally on data_valid. While data_ready is
// low the producer must keep data_valid and data_in stable; nothing is
// captured and a held byte is never overwritten.
//
// Timing: tx, busy and tx_done are registered from the current FSM state, so
// the line trails the state register by one cycle. A byte accepted at edge N
// into an idle transmitter is loaded at edge N+1 and the start bit appears on
// tx from edge N+2.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output tx_state_e  dbg_state_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be in 2..255");
    end

    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_e  state_q,     state_d;
    logic [7:0] shift_q,     shift_d;
    logic [7:0] hold_q,      hold_d;
    logic       hold_full_q, hold_full_d;
    // Indexes data bits in DATA and stop bits in STOP.
    logic [2:0] bit_idx_q,   bit_idx_d;
    logic       tx_q,        tx_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;

    logic accept;
    logic load;
    logic tick;

    assign accept = data_valid && !hold_full_q;

    // ------------------------------------------------------------------
    // Bit timer: held at 0 while idle, free-running through a frame and
    // across back-to-back frames, wrapping at every bit boundary.
    // ------------------------------------------------------------------
    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == ST_IDLE),
        .tick_o    (tick)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end

            ST_START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end

            ST_DATA: begin
                tx_d = shift_q[bit_idx_q];
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                tx_d = parity_bit(shift_q, PARITY);
                if (tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_STOP;
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        // A waiting byte goes straight into the next start
                        // bit so back-to-back frames have no idle gap.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = 3'd0;
            state_d     = ST_START;
        end

        // Refill wins over the load's clear so the holding register stays
        // full when a load and a new accept land on the same edge.
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_ready  = !hold_full_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Three transmitter instances ("lanes") with different configurations run in
// parallel from one clock:
//   lane 0: CLKS_PER_BIT=104, no parity,   1 stop bit
//   lane 1: CLKS_PER_BIT=7,   even parity, 2 stop bits
//   lane 2: CLKS_PER_BIT=3,   odd parity,  1 stop bit (all 256 values back-to-back)
//
// The reference model for each lane is a schedule of frames: each accepted
// byte gets a start cycle (two edges after acceptance, or the cycle after the
// previous frame ends, whichever is later). The expected line level in any
// cycle is read from the frame's bit list at (cycle - start) / CLKS_PER_BIT.
// busy, tx_done and data_ready follow from the same schedule.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        int         start;
        logic [7:0] data;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Level of bit slot k of a frame: 0 start, 1..8 data LSB first,
    // optional parity, then stop bits (high).
    function automatic logic exp_bit(input logic [7:0] d, input int k, input int par);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && par != 0) return (par == 1) ? (^d) : ~(^d);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CPB   = (g == 0) ? 104 : ((g == 1) ? 7 : 3);
        localparam int PAR   = g;
        localparam int STB   = (g == 1) ? 2 : 1;
        localparam int FLEN  = (9 + ((PAR != 0) ? 1 : 0) + STB) * CPB;
        localparam int NRAND = (g == 0) ? 4 : ((g == 1) ? 120 : 256);
        localparam bit SWEEP = (g == 2);

        logic       rst;
        logic [7:0] data_in;
        logic       data_valid;
        logic       data_ready;
        logic       tx;
        logic       busy;
        logic       tx_done;
        tx_state_e  dbg_state;

        frame_t exp_q[$];
        int     cyc       = 0;
        int     acc_cnt   = 0;
        bit     done_flag = 1'b0;

        uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY       (PAR),
            .STOP_BITS    (STB)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .data_in     (data_in),
            .data_valid  (data_valid),
            .data_ready  (data_ready),
            .tx          (tx),
            .busy        (busy),
            .tx_done     (tx_done),
            .dbg_state_o (dbg_state)
        );

        // ---------------- reference model: acceptance and scheduling ----------
        always @(posedge clk or negedge rst) begin : model
            logic rdy;
            int   st;
            frame_t f;
            if (!rst) begin
                exp_q.delete();
                cyc = 0;
            end else begin
                rdy = (exp_q.size() == 0) || (cyc >= exp_q[$].start - 1);
                cyc = cyc + 1;
                if (data_valid && rdy) begin
                    st = cyc + 2;
                    if (exp_q.size() != 0 && exp_q[$].start + FLEN > st)
                        st = exp_q[$].start + FLEN;
                    f.start = st;
                    f.data  = data_in;
                    exp_q.push_back(f);
                    acc_cnt++;
                end
            end
        end

        // ---------------- per-cycle comparison of all outputs -----------------
        always @(negedge clk) begin : mon
            logic e_tx, e_busy, e_done, e_rdy;
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
            if (rst) begin
                while (exp_q.size() != 0 && cyc >= exp_q[0].start + FLEN)
                    void'(exp_q.pop_front());
                if (exp_q.size() != 0 && cyc >= exp_q[0].start) begin
                    e_tx   = exp_bit(exp_q[0].data, (cyc - exp_q[0].start) / CPB, PAR);
                    e_busy = 1'b1;
                    e_done = (cyc == exp_q[0].start + FLEN - 1);
                end
                e_rdy = (exp_q.size() == 0) || (cyc >= exp_q[$].start - 1);
            end
            chk($sformatf("L%0d_tx", g),      tx,         e_tx);
            chk($sformatf("L%0d_busy", g),    busy,       e_busy);
            chk($sformatf("L%0d_tx_done", g), tx_done,    e_done);
            chk($sformatf("L%0d_ready", g),   data_ready, e_rdy);
        end

        // ---------------- driver tasks ----------------------------------------
        task automatic send(input logic [7:0] b, input bit keep_valid);
            int n0;
            int t;
            n0 = acc_cnt;
            t  = 0;
            data_in    = b;
            data_valid = 1'b1;
            while (acc_cnt == n0 && t < 4 * FLEN + 10) begin
                @(posedge clk); #1;
                t++;
            end
            chk($sformatf("L%0d_accept_%0h", g, b), 32'(acc_cnt - n0), 1);
            if (!keep_valid) data_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 6 * FLEN) begin
                @(posedge clk); #1;
                t++;
            end
            chk($sformatf("L%0d_idle_reached", g), 32'(exp_q.size()), 0);
            repeat (2) begin @(posedge clk); #1; end
        endtask

        // ---------------- stimulus --------------------------------------------
        initial begin : drive
            int  t;
            int  gap;
            bit  keep;
            bit  ok;
            logic [7:0] b;

            rst        = 1'b0;
            data_valid = 1'b0;
            data_in    = 8'h00;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;

            // Isolated frame, then a back-to-back pair with valid held high.
            send(8'h55, 1'b0);
            wait_idle();
            send(8'hA5, 1'b1);
            send(8'h3C, 1'b0);
            wait_idle();

            // Parity corner values and an all-ones frame.
            send(8'h07, 1'b0);
            wait_idle();
            send(8'h00, 1'b0);
            send(8'hFF, 1'b0);
            wait_idle();

            // Reset in the middle of the data bits with a second byte held.
            send(8'h12, 1'b1);
            send(8'h34, 1'b0);
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 4 * FLEN) begin
                ok = (exp_q.size() == 2) && (cyc >= exp_q[0].start + 4 * CPB);
                if (!ok) begin
                    @(posedge clk); #1;
                    t++;
                end
            end
            chk($sformatf("L%0d_rst_setup", g), ok, 1);
            #2 rst = 1'b0;
            #1;
            chk($sformatf("L%0d_async_tx", g),    tx,         1);
            chk($sformatf("L%0d_async_busy", g),  busy,       0);
            chk($sformatf("L%0d_async_done", g),  tx_done,    0);
            chk($sformatf("L%0d_async_ready", g), data_ready, 1);
            chk($sformatf("L%0d_async_state", g), 32'(dbg_state), 32'(ST_IDLE));
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            send(8'h81, 1'b0);
            wait_idle();

            // Random (or sweeping) traffic, mostly back-to-back.
            for (int i = 0; i < NRAND; i++) begin
                b    = SWEEP ? 8'(i) : 8'($urandom_range(0, 255));
                keep = SWEEP ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (i == NRAND - 1) keep = 1'b0;
                send(b, keep);
                if (!keep) begin
                    gap = $urandom_range(0, 2 * CPB);
                    repeat (gap) begin @(posedge clk); #1; end
                end
            end
            wait_idle();
            done_flag = 1'b1;
        end
    end

    // ---------------- end of test -------------------------------------------
    initial begin : finish_ctl
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = lane[0].done_flag && lane[1].done_flag && lane[2].done_flag;
        end
        chk("all_lanes_done", all_done, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter, LSB first, idle-high line.
- Pairs with the team's UART receiver and uses the same CLKS_PER_BIT timing (12 MHz / 115200).
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so frames can go back-to-back with no idle gap.
- Optional parity and 1 or 2 stop bits; sits between the fabric command logic and the FTDI TX pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period; legal range 2..255.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  byte to send; sampled when data_valid && data_ready.
- data_valid  in  1  producer has a byte.
- data_ready  out  1  holding register empty; high means a byte can be accepted this cycle.
- tx  out  1  serial line; registered, idle high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset, asynchronous, on rst low:
  - tx=1, busy=0, tx_done=0, data_ready=1.
  - state=IDLE; counters 0; holding register empty.
- Handshake: accept when data_valid && data_ready at a clk edge. data_in is latched into the holding register and data_ready drops the next cycle.
- data_ready = !hold_full. It is a registered flag, not combinational from data_valid.
- States:
  - IDLE: tx=1. If hold_full, load the shift register, clear hold_full, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_index=0.
  - DATA: tx=shift[bit_index] for CLKS_PER_BIT cycles per bit, 8 bits LSB first. After bit 7, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = XOR of the 8 data bits (even), or its inverse (odd), for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the last cycle assert tx_done. If hold_full, go directly to START (load shift, clear hold_full); else go to IDLE.
- Latency: a byte accepted at edge N into an empty holding register with the FSM in IDLE gives tx=0 from edge N+2 (one edge to latch, one to load and start).
- Frame length: (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P = (PARITY!=0).
- Back-to-back: with the holding register full at the end of STOP, the next start bit begins the cycle immediately after the final stop cycle, with zero idle cycles.
- Accept while transmitting: allowed whenever hold_full=0. When the shift register loads on the same edge as a new accept, hold_full stays 1 (load and refill in the same cycle).
- Counter: the bit-timer is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 at each bit boundary. No cycle-level drift is allowed.
- busy falls in the cycle after tx_done unless a back-to-back frame starts.
- Reset mid-frame: tx returns to 1 asynchronously and any pending held byte is discarded. No tx_done is emitted.
- data_valid with data_ready low: ignored, and the producer must hold data. A byte already held must not be overwritten.
- Illegal PARITY (3) or STOP_BITS (0 or >2) is a parameter check error at elaboration.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity constants PARITY_NONE, PARITY_EVEN, PARITY_ODD;
  - default CLKS_PER_BIT = 104.
- One natural sub-module, uart_baud_counter: a bit-period timer with restart input and a tick output at count CLKS_PER_BIT-1. The receiver can later reuse it.

Test Plan:
- Send 0x55, PARITY=0, STOP_BITS=1 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each exactly 104 cycles; tx_done pulses once at cycle 1040 of the frame; busy covers 1040 cycles.
- Present 0xA5 then 0x3C with data_valid held high -> second accepted while the first is shifting; second start bit begins the cycle after the first tx_done (zero gap); data_ready low while the holding register is full.
- PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; PARITY=1 with 0x00 -> 0; frames are 1144 cycles.
- STOP_BITS=2, send 0xFF -> line high for 208 cycles after bit 7; tx_done in the final stop cycle only.
- Assert rst low mid-DATA with a byte held -> tx=1 immediately (asynchronous), data_ready=1, busy=0, no tx_done. The next accepted 0x81 transmits correctly.
- Loopback into the team's UART receiver at CLKS_PER_BIT=104 for all 256 values, back-to-back -> every received byte matches in order, one data_valid per byte.
